// File: rtl/ved_pkg.sv
// Shared definitions for the restoring divider.
// - state_e   : divider FSM states
// - VED_PROD_W: default product width of the 2x2 Vedic multiplier (dividend/quotient)
// - VED_OPND_W: default operand width of the multiplier (divisor/remainder)
// - cnt_width : width of a step counter that must hold the value dvd_w
package ved_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  localparam int unsigned VED_PROD_W = 4;
  localparam int unsigned VED_OPND_W = 2;

  function automatic int unsigned cnt_width(input int unsigned dvd_w);
    return $clog2(dvd_w + 1);
  endfunction

endpackage

// File: rtl/ved_div_step.sv
// One combinational restoring-division step.
// Ports:
//   r       in  DVS_W+1  current partial remainder
//   bit_in  in  1        next dividend bit (MSB first)
//   divisor in  DVS_W    divisor
//   r_next  out DVS_W+1  partial remainder after the step
//   q_bit   out 1        quotient bit produced by the step
module ved_div_step #(
  parameter int unsigned DVS_W = 2
) (
  input  logic [DVS_W:0]   r,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W:0]   r_next,
  output logic             q_bit
);

  logic [DVS_W:0] r_shift;
  logic [DVS_W:0] dvs_ext;

  always_comb begin
    // r is always below the divisor, so dropping its MSB loses nothing.
    r_shift = {r[DVS_W-1:0], bit_in};
    dvs_ext = {1'b0, divisor};
    q_bit   = (r_shift >= dvs_ext);
    r_next  = q_bit ? (r_shift - dvs_ext) : r_shift;
  end

endmodule

// File: rtl/ved_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Ports:
//   clk         in  1      rising-edge clock
//   rst_n       in  1      asynchronous active-low reset
//   start       in  1      request, sampled only in idle
//   dividend    in  DVD_W  unsigned dividend, captured with start
//   divisor     in  DVS_W  unsigned divisor, captured with start
//   busy        out 1      high while the division steps run
//   done        out 1      one-cycle pulse, results valid from this cycle
//   quotient    out DVD_W  unsigned quotient (all ones on divide by zero)
//   remainder   out DVS_W  unsigned remainder
//   div_by_zero out 1      captured divisor was zero
module ved_restoring_divider
  import ved_pkg::*;
#(
  parameter int unsigned DVD_W = VED_PROD_W,
  parameter int unsigned DVS_W = VED_OPND_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(DVD_W);

  state_e           state_q;
  logic [DVD_W-1:0] dvd_q;
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W:0]   rem_q;
  logic [CntW-1:0]  cnt_q;

  logic [DVS_W:0]   rem_next;
  logic             q_bit;
  logic [DVD_W-1:0] quo_next;

  ved_div_step #(
    .DVS_W(DVS_W)
  ) u_step (
    .r      (rem_q),
    .bit_in (dvd_q[DVD_W-1]),
    .divisor(dvs_q),
    .r_next (rem_next),
    .q_bit  (q_bit)
  );

  assign quo_next = {quo_q[DVD_W-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (divisor == '0) begin
              state_q     <= StFin;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              state_q     <= StRun;
              busy        <= 1'b1;
              dvd_q       <= dividend;
              dvs_q       <= divisor;
              rem_q       <= '0;
              quo_q       <= '0;
              cnt_q       <= CntW'(DVD_W);
              div_by_zero <= 1'b0;
            end
          end
        end
        StRun: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q - CntW'(1);
          // Last step: publish results on the way into StFin.
          if (cnt_q == CntW'(1)) begin
            state_q   <= StFin;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= quo_next;
            remainder <= rem_next[DVS_W-1:0];
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ved_restoring_divider.sv
module tb_ved_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [1:0] remainder;
  logic       div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int dbz;
  } exp_t;

  exp_t sb[$];

  ved_restoring_divider #(
    .DVD_W(4),
    .DVS_W(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        if (e.dbz == 0) begin
          chk("q*d+r", int'(quotient) * e.dvs + int'(remainder), e.dvd);
          chk("r<d", int'(remainder) < e.dvs, 1);
        end
      end
    end
  end

  task automatic push(input int a, input int b, input int q, input int r, input int z);
    exp_t e;
    e.dvd = a; e.dvs = b; e.q = q; e.r = r; e.dbz = z;
    sb.push_back(e);
  endtask

  // Counts negedges from the accepting edge until done; flags a timeout.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_op(input int a, input int b, input int q, input int r, input int z,
                        output int cyc, output int busy_cnt);
    push(a, b, q, r, z);
    dividend = 4'(a);
    divisor  = 2'(b);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, busy_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int bc;

    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic division with latency and busy-length checks.
    run_op(9, 2, 4, 1, 0, cyc, bc);
    chk("lat_9_2", cyc, 5);
    chk("busy_9_2", bc, 4);

    run_op(15, 3, 5, 0, 0, cyc, bc);
    run_op(0, 1, 0, 0, 0, cyc, bc);

    // Divide by zero, then a legal start clears the flag right away.
    run_op(7, 0, 15, 0, 1, cyc, bc);
    chk("lat_div0", cyc, 1);
    chk("busy_div0", bc, 0);
    push(9, 2, 4, 1, 0);
    dividend = 4'd9;
    divisor  = 2'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("dbz_cleared", div_by_zero, 0);
    chk("busy_after_start", busy, 1);
    wait_done(cyc, bc);
    @(posedge clk);
    #1;

    // Start during RUN is ignored; only 6/3 completes.
    push(6, 3, 2, 0, 0);
    dividend = 4'd6;
    divisor  = 2'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    dividend = 4'd15;
    divisor  = 2'd1;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bc);
    repeat (8) @(negedge clk);
    chk("single_done", sb.size(), 0);
    @(posedge clk);
    #1;

    // Start held high: back-to-back accepts every 6 cycles.
    push(6, 3, 2, 0, 0);
    push(15, 3, 5, 0, 0);
    dividend = 4'd6;
    divisor  = 2'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = 4'd15;
    wait_done(cyc, bc);
    chk("held_first_lat", cyc, 5);
    wait_done(cyc, bc);
    chk("held_second_gap", cyc, 6);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Reset asserted in the third RUN cycle of 13/2.
    dividend = 4'd13;
    divisor  = 2'd2;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_quotient", quotient, 0);
    chk("async_remainder", remainder, 0);
    chk("async_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end
    @(posedge clk);
    #1;
    run_op(13, 2, 6, 1, 0, cyc, bc);

    // Every nonzero-divisor pair.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 4; b++) begin
        run_op(a, b, a / b, a % b, 0, cyc, bc);
      end
    end

    // Products of the 2x2 multiplier divide back to their factor.
    for (int a = 0; a < 4; a++) begin
      for (int b = 1; b < 4; b++) begin
        run_op(a * b, b, a, 0, 0, cyc, bc);
      end
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
